// File: rtl/arb8_rr_12_pkg.sv
// Shared constants, state encoding and helpers for the 8-source round-robin mux arbiter.
package arb8_rr_12_pkg;

   localparam int N_SRC  = 8;
   localparam int SEL_W  = 3;
   localparam int HOLD_W = 8;

   localparam logic [HOLD_W-1:0] HOLD_SAT = {HOLD_W{1'b1}};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
      return N_SRC'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick8_12.sv
// Combinational round-robin search: first eligible request at or after `start`, modulo 8.
module rr_pick8_12
   import arb8_rr_12_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  logic [SEL_W-1:0] start,
   input  logic [N_SRC-1:0] mask,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [N_SRC-1:0] elig;
   logic [N_SRC-1:0] rot;
   logic [SEL_W-1:0] rot_idx;

   assign elig = req & ~mask;

   // rot[i] is the source that sits i places after start; 3-bit sum wraps 7 -> 0.
   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_rot
         logic [SEL_W-1:0] src;
         assign src     = SEL_W'(gi) + start;
         assign rot[gi] = elig[src];
      end
   endgenerate

   always_comb begin
      rot_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (rot[i]) begin
            rot_idx = SEL_W'(i);
         end
      end
   end

   assign found = |rot;
   assign idx   = rot_idx + start;

endmodule

// File: rtl/arb8_rr_12.sv
// Round-robin arbiter driving the select of a shared 8:1 one-bit mux, with bounded grant tenure.
module arb8_rr_12
   import arb8_rr_12_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_SRC-1:0]  req,
   output logic [N_SRC-1:0]  gnt,
   output logic [SEL_W-1:0]  sel,
   output logic              gnt_valid,
   output logic [HOLD_W-1:0] hold_cnt
);

   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

   state_t           state;
   logic [SEL_W-1:0] last;

   logic             cur_req;
   logic             others;
   logic             expired;
   logic             keep;
   logic [N_SRC-1:0] pick_mask;
   logic [SEL_W-1:0] pick_start;
   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;
   logic [HOLD_W-1:0] hold_inc;

   // While busy, last always equals sel, so one start pointer serves both states.
   always_comb begin
      cur_req    = (state == ST_BUSY) && req[sel];
      others     = |(req & ~gnt);
      expired    = hold_cnt >= HOLD_LIM;
      keep       = cur_req && (!expired || !others);
      pick_start = last + SEL_W'(1);
      pick_mask  = cur_req ? gnt : '0;
      hold_inc   = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HOLD_W'(1);
   end

   rr_pick8_12 u_pick (
      .req   (req),
      .start (pick_start),
      .mask  (pick_mask),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         last      <= SEL_W'(N_SRC - 1);
         gnt       <= '0;
         sel       <= '0;
         gnt_valid <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state     <= ST_BUSY;
                  last      <= pick_idx;
                  gnt       <= onehot(pick_idx);
                  sel       <= pick_idx;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= HOLD_W'(1);
               end
            end
            ST_BUSY: begin
               if (keep) begin
                  // Expired tenure with nobody waiting restarts the count.
                  hold_cnt <= expired ? HOLD_W'(1) : hold_inc;
               end else if (pick_found) begin
                  last      <= pick_idx;
                  gnt       <= onehot(pick_idx);
                  sel       <= pick_idx;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= HOLD_W'(1);
               end else begin
                  state     <= ST_IDLE;
                  gnt       <= '0;
                  sel       <= '0;
                  gnt_valid <= 1'b0;
                  hold_cnt  <= '0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               gnt       <= '0;
               sel       <= '0;
               gnt_valid <= 1'b0;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arb8_rr_12.sv
// Scoreboard bench for arb8_rr_12: two instances (MAX_HOLD 16 and 4) share one req stimulus.
module tb_arb8_rr_12;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       valid;
      logic [7:0] hold;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt_o   [2];
   logic [2:0] sel_o   [2];
   logic       valid_o [2];
   logic [7:0] hold_o  [2];

   exp_t q0[$];
   exp_t q1[$];

   int owner [2];
   int ten   [2];
   int lastp [2];
   int waitc [2][8];
   int max_wait [2];

   int n_cmp = 0;
   int n_bad = 0;

   arb8_rr_12 #(.MAX_HOLD(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_o[0]), .sel(sel_o[0]), .gnt_valid(valid_o[0]), .hold_cnt(hold_o[0])
   );

   arb8_rr_12 #(.MAX_HOLD(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_o[1]), .sel(sel_o[1]), .gnt_valid(valid_o[1]), .hold_cnt(hold_o[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int mh(input int i);
      return (i == 0) ? 16 : 4;
   endfunction

   // First requester strictly after `from`, going round the ring, skipping `excl`.
   function automatic int rr_search(input logic [7:0] r, input int from, input int excl);
      for (int k = 1; k <= 8; k++) begin
         int c;
         c = (from + k) % 8;
         if (r[c] && c != excl) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         owner[i] = -1;
         ten[i]   = 0;
         lastp[i] = 7;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic model_step(input int i, input logic [7:0] r);
      int  g;
      int  w;
      bit  others;
      if (owner[i] < 0) begin
         w = rr_search(r, lastp[i], -1);
         if (w >= 0) begin
            owner[i] = w; ten[i] = 1; lastp[i] = w;
         end
      end else begin
         g = owner[i];
         others = (r & ~(8'(1) << g)) != 8'h00;
         if (r[g] && ten[i] < mh(i)) begin
            ten[i] = (ten[i] >= 255) ? 255 : ten[i] + 1;
         end else if (r[g] && !others) begin
            ten[i] = 1;
         end else begin
            w = rr_search(r, g, g);
            if (w >= 0) begin
               owner[i] = w; ten[i] = 1; lastp[i] = w;
            end else begin
               owner[i] = -1; ten[i] = 0;
            end
         end
      end
   endtask

   function automatic exp_t model_out(input int i);
      exp_t e;
      e.gnt   = (owner[i] >= 0) ? (8'(1) << owner[i]) : 8'h00;
      e.sel   = (owner[i] >= 0) ? 3'(owner[i]) : 3'd0;
      e.valid = (owner[i] >= 0);
      e.hold  = 8'(ten[i]);
      return e;
   endfunction

   task automatic check(input string name, input int act, input int req_v);
      n_cmp++;
      if (act != req_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req_v);
      end
   endtask

   // Reference model: advances on each edge and queues the expected outputs.
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            model_step(0, req);
            model_step(1, req);
            q0.push_back(model_out(0));
            q1.push_back(model_out(1));
         end
      end
   end

   // Monitor: compares DUT outputs with the queued expectation every edge; tracks waiting time.
   initial begin
      exp_t e;
      exp_t a;
      for (int i = 0; i < 2; i++) begin
         max_wait[i] = 0;
         for (int k = 0; k < 8; k++) waitc[i][k] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            for (int i = 0; i < 2; i++)
               for (int k = 0; k < 8; k++) waitc[i][k] = 0;
         end else begin
            for (int i = 0; i < 2; i++) begin
               a = {gnt_o[i], sel_o[i], valid_o[i], hold_o[i]};
               n_cmp++;
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  n_bad++;
                  $display("FAIL scoreboard_empty inst%0d: got outputs but nothing expected", i);
               end else begin
                  e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  if (a !== e) begin
                     n_bad++;
                     $display("FAIL scoreboard inst%0d t=%0t: got gnt=%h sel=%0d v=%0b hold=%0d, required gnt=%h sel=%0d v=%0b hold=%0d",
                              i, $time, a.gnt, a.sel, a.valid, a.hold, e.gnt, e.sel, e.valid, e.hold);
                  end
               end
               for (int k = 0; k < 8; k++) begin
                  if (req[k] && !gnt_o[i][k]) waitc[i][k]++;
                  else waitc[i][k] = 0;
                  if (waitc[i][k] > max_wait[i]) max_wait[i] = waitc[i][k];
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      @(negedge clk);
      req = 8'h00;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_gnt%0d", name, i), int'(gnt_o[i]), 0);
         check($sformatf("%s_sel%0d", name, i), int'(sel_o[i]), 0);
         check($sformatf("%s_valid%0d", name, i), int'(valid_o[i]), 0);
         check($sformatf("%s_hold%0d", name, i), int'(hold_o[i]), 0);
      end
   endtask

   initial begin
      int exp_sel;
      logic [7:0] r;
      rst_n = 1'b0;
      req   = 8'h00;
      repeat (2) @(posedge clk);
      #2;
      check_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single requester held for 40 cycles: never lost, count wraps at MAX_HOLD.
      req = 8'h08;
      for (int j = 0; j < 40; j++) begin
         @(posedge clk);
         #2;
         check("single_gnt16", int'(gnt_o[0]), 8);
         check("single_sel16", int'(sel_o[0]), 3);
         check("single_hold16", int'(hold_o[0]), (j % 16) + 1);
         check("single_hold4", int'(hold_o[1]), (j % 4) + 1);
      end

      // Asynchronous reset in the middle of a grant.
      #1;
      rst_n = 1'b0;
      req   = 8'h00;
      #1;
      check_zero("async_reset");
      repeat (2) begin
         @(posedge clk);
         #2;
         check_zero("reset_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Rotation: all request, each owner drops after two granted cycles.
      do_reset();
      req = 8'hFF;
      for (int j = 0; j < 18; j++) begin
         @(posedge clk);
         #2;
         check("rotate_sel", int'(sel_o[0]), (j / 2) % 8);
         check("rotate_valid", int'(valid_o[0]), 1);
         @(negedge clk);
         req = (ten[0] == 2) ? (8'hFF & ~(8'(1) << owner[0])) : 8'hFF;
      end
      idle_cycles(2);

      // Tenure expiry: sources 0 and 7 alternate every MAX_HOLD=4 cycles.
      do_reset();
      req = 8'h81;
      for (int j = 0; j < 12; j++) begin
         @(posedge clk);
         #2;
         exp_sel = ((j / 4) % 2 == 1) ? 7 : 0;
         check("tenure_sel4", int'(sel_o[1]), exp_sel);
         check("tenure_sel16", int'(sel_o[0]), 0);
      end
      idle_cycles(2);

      // Wrap-around with simultaneous release and new requests.
      do_reset();
      req = 8'h40;
      @(posedge clk); #2;
      check("wrap_sel6", int'(sel_o[0]), 6);
      @(negedge clk); req = 8'h23;
      @(posedge clk); #2;
      check("wrap_sel0", int'(sel_o[0]), 0);
      check("wrap_sel0_b", int'(sel_o[1]), 0);
      @(negedge clk); req = 8'h22;
      @(posedge clk); #2;
      check("wrap_sel1", int'(sel_o[0]), 1);
      @(negedge clk); req = 8'h20;
      @(posedge clk); #2;
      check("wrap_sel5", int'(sel_o[0]), 5);
      idle_cycles(2);

      // Random traffic; bits mostly persist so long waits get exercised.
      for (int i = 0; i < 2; i++) max_wait[i] = 0;
      r = 8'($urandom);
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         for (int k = 0; k < 8; k++)
            if ($urandom_range(0, 15) == 0) r[k] = ~r[k];
         if (owner[0] >= 0 && $urandom_range(0, 11) == 0) r[owner[0]] = 1'b0;
         req = r;
      end
      idle_cycles(3);

      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (max_wait[i] > 7 * mh(i) + 1) begin
            n_bad++;
            $display("FAIL starvation_bound inst%0d: got wait %0d, required <= %0d",
                     i, max_wait[i], 7 * mh(i) + 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/arb8_rr_12.md
# arb8_rr_12

Round-robin arbiter that shares one 8:1 one-bit multiplexer among eight requesters. It sequences the mux select so exactly one source is routed to the output at a time. Each grant is held while its requester keeps asking, up to a bounded tenure, so no requester starves. It sits directly in front of the 8:1 mux, and its `sel` output drives the mux select bus.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant is held while other requests are pending (legal range 1..255).
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, 8: request lines; `req[k]` high means source k wants the mux.
- `gnt`, output, 8: one-hot grant, registered; all zero when idle.
- `sel`, output, 3: encoded index of the granted source, registered; it drives the mux `s[2:0]`.
- `gnt_valid`, output, 1: high when `gnt` is nonzero.
- `hold_cnt`, output, 8: cycles the current grant has been held, counting from 1 in the first granted cycle; 0 when idle.

## Operation
- The design is one clock, with reset asynchronous and active-low.
- There are two states:
  - IDLE: no grant.
  - BUSY: one grant is active.
- Reset puts the block in IDLE with `gnt` = 0, `sel` = 0, `gnt_valid` = 0, `hold_cnt` = 0 and last pointer `last` = 7. With `last` = 7, the first search starts at source 0.
- Search rule: pick the first set bit of `req` scanning `last+1`, `last+2`, … modulo 8. Wrap-around from 7 to 0 is continuous.
- From IDLE:
  - If any `req` bit is set, grant the search winner: go to BUSY, `hold_cnt` = 1, `last` = winner.
  - Otherwise stay in IDLE.
- In BUSY with current grant g, evaluated each edge:
  - Keep the grant if `req[g]` = 1 and (`hold_cnt` < `MAX_HOLD` or no other `req` bit is set). Then `hold_cnt` increments, saturating at 255.
  - Re-arbitrate if `req[g]` = 0 or `hold_cnt` = `MAX_HOLD` with another request pending. The search starts from g+1 and excludes g when the tenure has expired.
    - If the search finds a winner, switch in the same edge with no dead cycle; `hold_cnt` = 1.
    - If nothing is pending, go to IDLE and clear all outputs.
- When the tenure expires with no other request pending, g keeps the grant and `hold_cnt` restarts at 1.
- A request that drops and reasserts between edges is invisible. The arbiter acts only on sampled values.
- `sel` always equals the binary encoding of `gnt`; it is 0 when idle. The mux output is meaningful only while `gnt_valid` = 1.

## Timing
- Latency from a request to its grant is 1 cycle, seen at the edge after `req` is sampled, when the mux is free.
- Release latency is 1 cycle. The edge that samples `req[g]` = 0 also installs the next winner.
- Worst-case wait for any continuously asserted request is 7 × `MAX_HOLD` cycles after the request is sampled, plus 1.
- `gnt`, `sel`, `gnt_valid` and `hold_cnt` are all registered outputs with no combinational path from `req`.
- `rst_n` asserted mid-grant clears every output immediately, without waiting for `clk`. Deassertion is synchronised externally, and the first edge after release behaves as IDLE.
- Simultaneous release of g and new requests at the same edge: the search runs from g+1 over the sampled `req`.

## Structure
- Shared package or header holds:
  - `N_SRC` = 8 and `SEL_W` = 3.
  - State encodings `ST_IDLE` = 1'b0 and `ST_BUSY` = 1'b1.
  - The `hold_cnt` width, 8.
- Sub-module `rr_pick8_12` is purely combinational. Its inputs are `req[7:0]`, `start[2:0]` and `mask[7:0]`. Its outputs are `found` and `idx[2:0]`. It implements the rotate, priority-encode and unrotate search.
- The top level holds the state flip-flop, `last`, `hold_cnt`, the `gnt`/`sel` registers, and the mux instance wiring in the parent.

## Test plan
- Reset and idle: assert `rst_n` low mid-grant, then hold `req` = 0.
  - `gnt` = 0, `sel` = 0, `gnt_valid` = 0 immediately, and they stay 0.
- Single requester:
  - Set `req` = 8'h08 → one cycle later `gnt` = 8'h08, `sel` = 3, `hold_cnt` = 1.
  - Hold for 40 cycles with `MAX_HOLD` = 16 → the grant is never lost, and `hold_cnt` wraps from 16 to 1.
- Rotation:
  - From reset, set `req` = 8'hFF and release each grant after 2 cycles → `sel` goes 0,1,2,…,7,0 with no idle cycle between grants.
- Tenure expiry:
  - With `req` = 8'h81 held, `MAX_HOLD` = 4 → `sel` alternates 0 (4 cycles), then 7 (4 cycles), repeating.
- Wrap and simultaneous events:
  - Grant source 6, then at one edge drop `req[6]` and set `req` = 8'h23 → next `sel` = 0 (search order 7,0,…), then 1, then 5.
- Starvation bound:
  - Random `req` for 10k cycles → assert `gnt` stays one-hot or zero, and `sel` always matches `gnt`.
  - Any continuously asserted request is granted within 7 × `MAX_HOLD` + 1 cycles.
